// File: rtl/ds_comp_adc_array.sv
// Comparator delta-sigma ADC array: per-channel feedback flops and CIC decimators,
// with a triggered serialiser that streams a snapshot of every channel's sample.
module ds_comp_adc_array #(
  parameter int CHANNELS   = 2,
  parameter int STAGES     = 4,
  parameter int DECIMATION = 8,
  parameter int OUT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] comp_in,
  input  logic                trigger,
  input  logic                diff_en,
  output logic [CHANNELS-1:0] pdm_out,
  output logic                sample_strobe,
  output logic                ser_data,
  output logic                ser_valid,
  output logic                busy
);
  // state | meaning
  // IDLE  | waiting for a start pulse, serial outputs low
  // SHIFT | frame buffer shifting out MSB first, one bit per cycle
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam int DW    = $clog2(DECIMATION);
  localparam int CIC_W = STAGES * DW + 1;
  localparam int FW    = (CHANNELS + 1) * OUT_W;
  localparam int CW    = $clog2(FW);
  localparam int WW    = $clog2(OUT_W);
  localparam logic [CW-1:0] LAST_ND = CW'(CHANNELS * OUT_W - 1);
  localparam logic [CW-1:0] LAST_D  = CW'(FW - 1);
  localparam logic [WW-1:0] WLAST   = WW'(OUT_W - 1);
  localparam logic [DW-1:0] DLAST   = DW'(DECIMATION - 1);

  logic [CHANNELS-1:0] ff_q, ff_d;
  logic [CIC_W-1:0]    integ_q [CHANNELS][STAGES];
  logic [CIC_W-1:0]    integ_d [CHANNELS][STAGES];
  logic [CIC_W-1:0]    dly_q   [CHANNELS][STAGES];
  logic [CIC_W-1:0]    dly_d   [CHANNELS][STAGES];
  logic [OUT_W-1:0]    sample_q [CHANNELS];
  logic [OUT_W-1:0]    sample_d [CHANNELS];
  logic [DW-1:0]       dec_q, dec_d;
  logic                strobe_q, strobe_d;
  logic [2:0]          sync_q, sync_d;
  logic [0:0]          state_q, state_d;
  logic [FW-1:0]       fb_q, fb_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WW-1:0]       wbit_q, wbit_d;

  logic                tick;
  logic                start;
  logic [CIC_W-1:0]    acc;
  logic [OUT_W-1:0]    ext;
  logic [OUT_W-1:0]    diff;

  assign tick  = (dec_q == DLAST);
  assign start = sync_q[1] & ~sync_q[2];
  assign diff  = sample_q[0] - sample_q[1];

  always_comb begin
    ff_d     = comp_in;
    dec_d    = dec_q + DW'(1);
    strobe_d = tick;
    acc      = '0;
    ext      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      integ_d[c][0] = integ_q[c][0] + CIC_W'(ff_q[c]);
      for (int s = 1; s < STAGES; s++) begin
        integ_d[c][s] = integ_q[c][s] + integ_q[c][s-1];
      end
      // Comb chain evaluated combinationally from the last integrator; only delays are stored.
      acc = integ_q[c][STAGES-1];
      for (int s = 0; s < STAGES; s++) begin
        dly_d[c][s] = tick ? acc : dly_q[c][s];
        acc         = acc - dly_q[c][s];
      end
      ext            = '0;
      ext[CIC_W-1:0] = acc;
      sample_d[c]    = tick ? ext : sample_q[c];
    end
  end

  always_comb begin
    sync_d  = {sync_q[1:0], trigger};
    state_d = state_q;
    fb_d    = fb_q;
    cnt_d   = cnt_q;
    wbit_d  = wbit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          fb_d    = '0;
          for (int c = 0; c < CHANNELS; c++) begin
            fb_d[FW-1-c*OUT_W -: OUT_W] = sample_q[c];
          end
          if (diff_en) fb_d[OUT_W-1:0] = diff;
          cnt_d  = diff_en ? LAST_D : LAST_ND;
          wbit_d = WLAST;
        end
      end
      SHIFT: begin
        fb_d   = {fb_q[FW-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        wbit_d = (wbit_q == '0) ? WLAST : wbit_q - WW'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          fb_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q     <= '1;
      dec_q    <= '0;
      strobe_q <= 1'b0;
      sync_q   <= '0;
      state_q  <= IDLE;
      fb_q     <= '0;
      cnt_q    <= '0;
      wbit_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sample_q[c] <= '0;
        for (int s = 0; s < STAGES; s++) begin
          integ_q[c][s] <= '0;
          dly_q[c][s]   <= '0;
        end
      end
    end else begin
      ff_q     <= ff_d;
      dec_q    <= dec_d;
      strobe_q <= strobe_d;
      sync_q   <= sync_d;
      state_q  <= state_d;
      fb_q     <= fb_d;
      cnt_q    <= cnt_d;
      wbit_q   <= wbit_d;
      for (int c = 0; c < CHANNELS; c++) begin
        sample_q[c] <= sample_d[c];
        for (int s = 0; s < STAGES; s++) begin
          integ_q[c][s] <= integ_d[c][s];
          dly_q[c][s]   <= dly_d[c][s];
        end
      end
    end
  end

  assign pdm_out       = ~ff_q;
  assign sample_strobe = strobe_q;
  assign busy          = (state_q == SHIFT);
  assign ser_data      = busy & fb_q[FW-1];
  assign ser_valid     = busy & (wbit_q == WLAST);

endmodule

// File: tb/tb_ds_comp_adc_array.sv
// Bench for ds_comp_adc_array: random and directed comparator streams checked every
// cycle against an impulse-response CIC model and a frame-level serialiser model.
module tb_ds_comp_adc_array;
  localparam int CH   = 2;
  localparam int ST   = 4;
  localparam int DEC  = 8;
  localparam int OW   = 16;
  localparam int CICW = ST * $clog2(DEC) + 1;
  localparam int NTAP = ST * (DEC - 1) + 1;
  localparam int HMAX = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] comp_in = '0;
  logic          trigger = 1'b0;
  logic          diff_en = 1'b0;
  logic [CH-1:0] pdm_out;
  logic          sample_strobe;
  logic          ser_data;
  logic          ser_valid;
  logic          busy;

  ds_comp_adc_array #(.CHANNELS(CH), .STAGES(ST), .DECIMATION(DEC), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .comp_in(comp_in), .trigger(trigger), .diff_en(diff_en),
    .pdm_out(pdm_out), .sample_strobe(sample_strobe), .ser_data(ser_data),
    .ser_valid(ser_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model state: cycle index since reset release, ff history, sampled trigger history.
  int             h [NTAP];
  bit             xh [CH][HMAX];
  bit             ts [HMAX];
  int             m;
  int             msamp [CH];
  bit             mstrobe;
  int             mw [CH+1];
  int             fstart;
  int             flen;
  logic [OW-1:0]  capw [CH+1];
  int             busy_cnt;
  int             mode;

  function automatic int yval(int c, int n);
    int a;
    a = 0;
    for (int j = 0; j < NTAP; j++) begin
      if (n - ST - j >= 0) a += h[j] * int'(xh[c][n-ST-j]);
    end
    return a % (1 << CICW);
  endfunction

  function automatic bit mbusy(int k);
    return (fstart >= 0) && (k >= fstart) && (k < fstart + flen);
  endfunction

  function automatic bit start_at(int k);
    return (k >= 2) && ts[k-1] && !ts[k-2];
  endfunction

  task automatic model_reset();
    m = 0;
    for (int c = 0; c < CH; c++) begin
      xh[c][0] = 1'b1;
      msamp[c] = 0;
    end
    ts[0]   = 1'b0;
    mstrobe = 1'b0;
    fstart  = -1;
    flen    = 0;
  endtask

  task automatic model_step();
    m++;
    if (m >= HMAX) begin
      $display("FAIL model_depth: cycle %0d reached limit %0d", m, HMAX);
      $fatal(1, "model history exhausted");
    end
    if (start_at(m-1) && !mbusy(m-1)) begin
      for (int c = 0; c < CH; c++) mw[c] = msamp[c];
      mw[CH] = (msamp[0] - msamp[1]) & ((1 << OW) - 1);
      flen   = (CH + (diff_en ? 1 : 0)) * OW;
      fstart = m;
      for (int w = 0; w <= CH; w++) capw[w] = '0;
    end
    mstrobe = ((m - 1) % DEC == DEC - 1);
    if (mstrobe) for (int c = 0; c < CH; c++) msamp[c] = yval(c, m - 1);
    for (int c = 0; c < CH; c++) xh[c][m] = comp_in[c];
    ts[m] = trigger;
  endtask

  task automatic compare();
    logic [CH-1:0] epdm;
    bit eb, ed, ev;
    int k;
    for (int c = 0; c < CH; c++) epdm[c] = ~xh[c][m];
    eb = mbusy(m);
    ed = 1'b0;
    ev = 1'b0;
    if (eb) begin
      k  = m - fstart;
      ed = mw[k/OW][OW-1-k%OW];
      ev = (k % OW == 0);
      capw[k/OW][OW-1-k%OW] = ser_data;
    end
    if (busy) busy_cnt++;
    chk("pdm_out", 64'(pdm_out), 64'(epdm));
    chk("sample_strobe", 64'(sample_strobe), 64'(mstrobe));
    chk("busy", 64'(busy), 64'(eb));
    chk("ser_data", 64'(ser_data), 64'(ed));
    chk("ser_valid", 64'(ser_valid), 64'(ev));
  endtask

  task automatic drive();
    comp_in = '0;
    case (mode)
      0: comp_in = '1;
      1: comp_in[0] = m[0];
      2: comp_in[0] = 1'b1;
      3: comp_in[1] = 1'b1;
      default: comp_in = CH'($urandom);
    endcase
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    compare();
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse();
    trigger = 1'b1;
    run(2);
    trigger = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    trigger = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ser_data", 64'(ser_data), 64'd0);
    chk("rst_ser_valid", 64'(ser_valid), 64'd0);
    chk("rst_pdm_out", 64'(pdm_out), 64'd0);
    chk("rst_strobe", 64'(sample_strobe), 64'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold_busy", 64'(busy), 64'd0);
    chk("rst_hold_ser", 64'(ser_data), 64'd0);
    rst_n = 1'b1;
    model_reset();
    drive();
  endtask

  initial begin
    int tmp [NTAP];
    int len;
    for (int i = 0; i < NTAP; i++) h[i] = 0;
    h[0] = 1;
    len  = 1;
    for (int s = 0; s < ST; s++) begin
      for (int i = 0; i < NTAP; i++) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int r = 0; r < DEC; r++) tmp[i+r] += h[i];
      h = tmp;
      len += DEC - 1;
    end

    // All ones: full-scale samples, frame without diff.
    mode = 0;
    diff_en = 1'b0;
    do_reset();
    run(60);
    busy_cnt = 0;
    pulse();
    run(40);
    chk("full_w0", 64'(capw[0]), 64'h1000);
    chk("full_w1", 64'(capw[1]), 64'h1000);
    chk("full_len", 64'(busy_cnt), 64'd32);

    // Alternating ch0, ch1 low, with diff word.
    mode = 1;
    run(60);
    diff_en  = 1'b1;
    busy_cnt = 0;
    pulse();
    run(55);
    chk("alt_w0", 64'(capw[0]), 64'd2048);
    chk("alt_w1", 64'(capw[1]), 64'd0);
    chk("alt_diff", 64'(capw[2]), 64'd2048);
    chk("alt_len", 64'(busy_cnt), 64'd48);

    // ch0 high: mid-frame trigger and diff_en change must not disturb the frame.
    mode = 2;
    run(60);
    diff_en  = 1'b1;
    busy_cnt = 0;
    pulse();
    run(18);
    pulse();
    diff_en = 1'b0;
    run(35);
    chk("hi_w0", 64'(capw[0]), 64'h1000);
    chk("hi_w1", 64'(capw[1]), 64'h0000);
    chk("hi_diff", 64'(capw[2]), 64'h1000);
    chk("hi_len", 64'(busy_cnt), 64'd48);
    busy_cnt = 0;
    pulse();
    run(40);
    chk("next_w0", 64'(capw[0]), 64'h1000);
    chk("next_w1", 64'(capw[1]), 64'h0000);
    chk("next_len", 64'(busy_cnt), 64'd32);

    // ch1 high: negative diff wraps.
    mode = 3;
    run(60);
    diff_en = 1'b1;
    pulse();
    run(55);
    chk("neg_w0", 64'(capw[0]), 64'h0000);
    chk("neg_w1", 64'(capw[1]), 64'h1000);
    chk("neg_diff", 64'(capw[2]), 64'hF000);

    // Snapshot on the same edge as a tick while samples are moving.
    mode = 0;
    run(60);
    mode = 2;
    run(8);
    while (m % DEC != DEC - 3) cyc();
    pulse();
    run(55);
    chk("tick_w0", 64'(capw[0]), 64'(mw[0]));
    chk("tick_w1", 64'(capw[1]), 64'(mw[1]));
    chk("tick_diff", 64'(capw[2]), 64'(mw[2]));

    // Random comparator bits, trigger edges and diff_en.
    mode = 4;
    for (int i = 0; i < 700; i++) begin
      cyc();
      if ($urandom_range(0, 24) == 0) trigger = ~trigger;
      if ($urandom_range(0, 9) == 0) diff_en = 1'($urandom);
    end
    trigger = 1'b0;
    run(60);

    // Reset mid-frame: abort, nothing left afterwards.
    mode = 2;
    diff_en = 1'b1;
    pulse();
    run(20);
    do_reset();
    busy_cnt = 0;
    run(80);
    chk("post_rst_busy_cycles", 64'(busy_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ds_comp_adc_array.md
DS_COMP_ADC_ARRAY -- requirements
Module: ds_comp_adc_array

Interface
REQ-001 Parameter CHANNELS, default 2: number of comparator channels; legal range 2..8.
REQ-002 Parameter STAGES, default 4: CIC order; legal range 1..5.
REQ-003 Parameter DECIMATION, default 8: CIC decimation ratio; must be a power of two in the range 4..64.
REQ-004 Parameter OUT_W, default 16: serialised word width; must satisfy OUT_W >= CIC_W, where CIC_W = STAGES*log2(DECIMATION)+1.
REQ-005 clk  input  1  clock; all logic on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 comp_in  input  CHANNELS  comparator outputs, one bit per channel.
REQ-008 trigger  input  1  asynchronous frame-request pulse.
REQ-009 diff_en  input  1  when high, append the word (ch0 - ch1) to each frame; sampled at frame start.
REQ-010 pdm_out  output  CHANNELS  inverted comparator flops, used as cap-drive feedback.
REQ-011 sample_strobe  output  1  one-cycle pulse marking each decimated-sample update.
REQ-012 ser_data  output  1  serial data, MSB first.
REQ-013 ser_valid  output  1  high only during the first (MSB) bit of each word.
REQ-014 busy  output  1  high while a frame is being shifted out.

Function
REQ-015 Per channel, a flop ff[i] shall register comp_in[i] every cycle, and pdm_out[i] shall equal ~ff[i].
REQ-016 Per channel, a CIC filter shall run: STAGES integrators clocked every cycle on the 0/1 value of ff[i]; STAGES combs clocked on the decimation tick.
REQ-017 All CIC arithmetic shall be CIC_W bits wide, unsigned, with modulo wrap-around; wrap shall not corrupt the comb output.
REQ-018 A shared decimation counter shall count 0..DECIMATION-1, and the tick shall occur on the cycle the count equals DECIMATION-1.
REQ-019 On the tick, every channel's comb output shall load into its sample register, zero-extended to OUT_W, and sample_strobe shall be high for the following cycle.
REQ-020 The trigger input shall pass through a 2-flop synchroniser followed by rising-edge detection; the detected edge shall be a one-cycle start pulse.
REQ-021 A start pulse while busy is low shall snapshot all sample registers, plus diff = sample[0] - sample[1] (two's complement, wrapped to OUT_W) when diff_en is high, into a frame buffer.
REQ-022 On a start pulse, busy shall rise on the same edge as the snapshot.
REQ-023 A start pulse while busy is high shall be ignored; no queuing is provided.
REQ-024 Frame order shall be channel 0 .. CHANNELS-1, then diff if enabled; each word is sent MSB first, one bit per cycle.
REQ-025 Frame length shall be NW*OUT_W cycles, where NW = CHANNELS + diff_en.
REQ-026 The first bit of a frame shall appear on ser_data on the cycle after the snapshot edge, i.e. 3 edges after trigger is first sampled high.
REQ-027 The controller shall be a state machine with states IDLE -> SHIFT -> IDLE; the SHIFT -> IDLE transition occurs after the last bit of the last word.
REQ-028 After the frame, busy, ser_data and ser_valid shall return low; a new frame may start on the next start pulse.
REQ-029 If a sample tick and a snapshot occur on the same edge, the snapshot shall capture the pre-update sample values.
REQ-030 Sample updates during SHIFT shall not alter the frame in flight.
REQ-031 Changes to diff_en during SHIFT shall have no effect until the next frame.

Reset
REQ-032 While rst_n is low: ff = all ones, so pdm_out = 0.
REQ-033 While rst_n is low: integrators, combs, samples, decimation counter, synchroniser and frame buffer = 0.
REQ-034 While rst_n is low: sample_strobe, ser_data, ser_valid and busy = 0, and the state machine is in IDLE.
REQ-035 Reset asserted mid-frame shall abort the frame immediately; after release, no residual bits are emitted.

Verification (defaults CHANNELS=2, STAGES=4, DECIMATION=8, OUT_W=16)
REQ-036 Reset, then comp_in = 2'b11 held -> pdm_out = 0. After settling (>= 5 ticks), both samples = 4096 and sample_strobe pulses every 8 cycles.
REQ-037 ch0 alternating 1,0 and ch1 = 0 -> sample0 settles to 2048 and sample1 = 0.
REQ-038 ch0 = 1, ch1 = 0, diff_en = 1, trigger pulse -> 48-bit frame 0x1000, 0x0000, 0x1000. ser_valid is high on bits 0, 16 and 32; busy is high for exactly 48 cycles.
REQ-039 Second trigger mid-frame -> ignored; frame length is unchanged, and the next trigger after busy falls is accepted.
REQ-040 ch0 = 0, ch1 = 1, diff_en = 1 -> diff word = 0xF000.
REQ-041 Trigger coincident with a sample tick -> frame carries the old values.
REQ-042 rst_n pulsed low mid-frame -> busy, ser_data and ser_valid are 0 within the reset, and no further bits follow.
